// File: rtl/traffic_lights_pkg.sv
// Shared definitions for the parametrised two-way traffic light controller.
// Contents:
//   state_t     - controller phases, including night flash mode
//   LAMP_*      - 3-bit lamp encodings {red,yellow,green}
//   SEG_BLANK   - 7-segment pattern for a dark digit
//   seg7_digit  - 7-segment table for decimal digits 0-9, {a,b,c,d,e,f,g} active-high
package traffic_lights_pkg;

  typedef enum logic [2:0] {
    RED_A,
    ROW_GREEN,
    ROW_YELLOW,
    RED_B,
    COL_GREEN,
    COL_YELLOW,
    FLASH
  } state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7_digit(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_digit = 7'b1111110;
      4'd1:    seg7_digit = 7'b0110000;
      4'd2:    seg7_digit = 7'b1101101;
      4'd3:    seg7_digit = 7'b1111001;
      4'd4:    seg7_digit = 7'b0110011;
      4'd5:    seg7_digit = 7'b1011011;
      4'd6:    seg7_digit = 7'b1011111;
      4'd7:    seg7_digit = 7'b1110000;
      4'd8:    seg7_digit = 7'b1111111;
      4'd9:    seg7_digit = 7'b1111011;
      default: seg7_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/segment_counter_display.sv
// Binary value to DIGITS-digit 7-segment countdown display.
// Values above 10^DIGITS-1 show as all nines; leading zeros are shown.
// Ports:
//   value    in  VALUE_W    unsigned binary value to show
//   blank    in  1          forces every segment dark
//   segments out 7*DIGITS   most significant digit in the top 7 bits
module segment_counter_display
  import traffic_lights_pkg::*;
#(
  parameter int VALUE_W = 7,
  parameter int DIGITS  = 2
) (
  input  logic [VALUE_W-1:0]  value,
  input  logic                blank,
  output logic [7*DIGITS-1:0] segments
);

  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS - 1);

  logic [31:0] rest;
  logic [3:0]  digit;

  // Digits are peeled off least significant first; division by a constant
  // keeps this a fixed combinational network.
  always_comb begin
    segments = '0;
    digit    = '0;
    rest     = 32'(value);
    if (rest > LIMIT) rest = LIMIT;
    for (int i = 0; i < DIGITS; i++) begin
      digit = 4'(rest % 32'd10);
      segments[7*i +: 7] = blank ? SEG_BLANK : seg7_digit(digit);
      rest = rest / 32'd10;
    end
  end

endmodule

// File: rtl/traffic_lights_param.sv
// Parametrised row/column intersection controller with night flash mode.
// Phases advance only on the one-cycle tick strobe; lamps and countdown
// displays are combinational decodes of the registered state.
// Optional feature macro: PED_REQUEST_EN (adds ped_request port and latch
// that shortens the current green to PED_GREEN_MIN ticks).
// Ports:
//   clock                  in  1         rising-edge clock
//   reset                  in  1         synchronous, active-low
//   tick                   in  1         advance strobe
//   night_mode             in  1         level request for flash mode
//   ped_request            in  1         pedestrian pulse (PED_REQUEST_EN only)
//   row_traffic_lights     out 3         {red,yellow,green}
//   column_traffic_lights  out 3         {red,yellow,green}
//   row_display            out 7*DIGITS  row countdown, MS digit first
//   column_display         out 7*DIGITS  column countdown, MS digit first
module traffic_lights_param
  import traffic_lights_pkg::*;
#(
  parameter int GREEN_TIME    = 25,
  parameter int YELLOW_TIME   = 5,
  parameter int ALL_RED_TIME  = 2,
  parameter int DIGITS        = 2,
  parameter int PED_GREEN_MIN = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                night_mode,
`ifdef PED_REQUEST_EN
  input  logic                ped_request,
`endif
  output logic [2:0]          row_traffic_lights,
  output logic [2:0]          column_traffic_lights,
  output logic [7*DIGITS-1:0] row_display,
  output logic [7*DIGITS-1:0] column_display
);

  // PED_GREEN_MIN never exceeds GREEN_TIME, so including it cannot widen the counter.
  localparam int MAX_A   = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
  localparam int MAX_B   = (ALL_RED_TIME > PED_GREEN_MIN) ? ALL_RED_TIME : PED_GREEN_MIN;
  localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam int SW      = CW + 2;

  localparam logic [CW-1:0] GREEN_LOAD   = CW'(GREEN_TIME - 1);
  localparam logic [CW-1:0] YELLOW_LOAD  = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] ALL_RED_LOAD = CW'(ALL_RED_TIME - 1);

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          flash, flash_n;

`ifdef PED_REQUEST_EN
  localparam logic [CW-1:0] PED_LOAD = CW'(PED_GREEN_MIN - 1);
  logic ped_latch, ped_latch_n;
  logic ped_active;
  // A fresh pulse shortens immediately rather than waiting a cycle for the latch.
  assign ped_active = ped_latch | ped_request;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= RED_A;
      count <= ALL_RED_LOAD;
      flash <= 1'b0;
`ifdef PED_REQUEST_EN
      ped_latch <= 1'b0;
`endif
    end else begin
      state <= state_n;
      count <= count_n;
      flash <= flash_n;
`ifdef PED_REQUEST_EN
      ped_latch <= ped_latch_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    flash_n = flash;
`ifdef PED_REQUEST_EN
    ped_latch_n = ped_latch;
    if (ped_request && state != FLASH) ped_latch_n = 1'b1;
`endif
    if (tick) begin
      if (state == FLASH) begin
        if (night_mode) begin
          flash_n = ~flash;
        end else begin
          state_n = RED_A;
          count_n = ALL_RED_LOAD;
          flash_n = 1'b0;
        end
      end else if (count != '0) begin
        count_n = count - CW'(1);
      end else begin
        case (state)
          RED_A, RED_B: begin
`ifdef PED_REQUEST_EN
            ped_latch_n = 1'b0;
`endif
            // Night mode is only honoured at an all-red boundary.
            if (night_mode) begin
              state_n = FLASH;
              flash_n = 1'b0;
            end else begin
              state_n = (state == RED_A) ? ROW_GREEN : COL_GREEN;
              count_n = GREEN_LOAD;
            end
          end
          ROW_GREEN: begin
            state_n = ROW_YELLOW;
            count_n = YELLOW_LOAD;
          end
          ROW_YELLOW: begin
            state_n = RED_B;
            count_n = ALL_RED_LOAD;
          end
          COL_GREEN: begin
            state_n = COL_YELLOW;
            count_n = YELLOW_LOAD;
          end
          default: begin
            state_n = RED_A;
            count_n = ALL_RED_LOAD;
          end
        endcase
      end
    end
`ifdef PED_REQUEST_EN
    if ((state == ROW_GREEN || state == COL_GREEN) && ped_active && count > PED_LOAD)
      count_n = PED_LOAD;
`endif
  end

  always_comb begin
    row_traffic_lights    = LAMP_RED;
    column_traffic_lights = LAMP_RED;
    case (state)
      ROW_GREEN:  row_traffic_lights    = LAMP_GREEN;
      ROW_YELLOW: row_traffic_lights    = LAMP_YELLOW;
      COL_GREEN:  column_traffic_lights = LAMP_GREEN;
      COL_YELLOW: column_traffic_lights = LAMP_YELLOW;
      FLASH: begin
        row_traffic_lights    = flash ? LAMP_YELLOW : LAMP_OFF;
        column_traffic_lights = flash ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  // A red direction shows the ticks until its own green: the rest of the
  // current phase plus every phase still queued before that green.
  logic [SW-1:0] remain, row_value, col_value;
  assign remain = SW'(count) + SW'(1);

  always_comb begin
    row_value = remain;
    col_value = remain;
    case (state)
      RED_A:      col_value = remain + SW'(GREEN_TIME + YELLOW_TIME + ALL_RED_TIME);
      ROW_GREEN:  col_value = remain + SW'(YELLOW_TIME + ALL_RED_TIME);
      ROW_YELLOW: col_value = remain + SW'(ALL_RED_TIME);
      RED_B:      row_value = remain + SW'(GREEN_TIME + YELLOW_TIME + ALL_RED_TIME);
      COL_GREEN:  row_value = remain + SW'(YELLOW_TIME + ALL_RED_TIME);
      COL_YELLOW: row_value = remain + SW'(ALL_RED_TIME);
      default: ;
    endcase
  end

  logic blank;
  assign blank = (state == FLASH);

  segment_counter_display #(.VALUE_W(SW), .DIGITS(DIGITS)) u_row_display (
    .value    (row_value),
    .blank    (blank),
    .segments (row_display)
  );

  segment_counter_display #(.VALUE_W(SW), .DIGITS(DIGITS)) u_column_display (
    .value    (col_value),
    .blank    (blank),
    .segments (column_display)
  );

endmodule

// File: tb/tb_traffic_lights_param.sv
// Self-checking bench for traffic_lights_param: directed vector table,
// hand-written multi-cycle sequences and randomized run against a
// phase-schedule reference model.
module tb_traffic_lights_param;

  localparam int GREEN_TIME    = 25;
  localparam int YELLOW_TIME   = 5;
  localparam int ALL_RED_TIME  = 2;
  localparam int DIGITS        = 2;
  localparam int PED_GREEN_MIN = 5;
  localparam int DW            = 7 * DIGITS;
`ifdef PED_REQUEST_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic night_mode = 1'b0;
  logic ped_request = 1'b0;
  logic [2:0]    row_traffic_lights, column_traffic_lights;
  logic [DW-1:0] row_display, column_display;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  traffic_lights_param #(
    .GREEN_TIME    (GREEN_TIME),
    .YELLOW_TIME   (YELLOW_TIME),
    .ALL_RED_TIME  (ALL_RED_TIME),
    .DIGITS        (DIGITS),
    .PED_GREEN_MIN (PED_GREEN_MIN)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .tick                  (tick),
    .night_mode            (night_mode),
`ifdef PED_REQUEST_EN
    .ped_request           (ped_request),
`endif
    .row_traffic_lights    (row_traffic_lights),
    .column_traffic_lights (column_traffic_lights),
    .row_display           (row_display),
    .column_display        (column_display)
  );

  // Reference model: phase schedule with remaining ticks in the phase.
  int         dur [6]         = '{ALL_RED_TIME, GREEN_TIME, YELLOW_TIME, ALL_RED_TIME, GREEN_TIME, YELLOW_TIME};
  logic [2:0] row_lamp_of [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] col_lamp_of [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  logic [6:0] seg_tab [10]    = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  int m_phase;
  bit m_flashing;
  int m_rem;
  bit m_fl;
  bit m_ped;

  task automatic model_reset();
    m_phase = 0; m_flashing = 0; m_rem = ALL_RED_TIME; m_fl = 0; m_ped = 0;
  endtask

  task automatic model_step();
    bit req, grn;
    if (!reset) begin
      model_reset();
      return;
    end
    req = PED_EN && (m_ped || ped_request);
    grn = !m_flashing && (m_phase == 1 || m_phase == 4);
    if (PED_EN && ped_request && !m_flashing) m_ped = 1;
    if (grn && req && m_rem > PED_GREEN_MIN) begin
      m_rem = PED_GREEN_MIN;
      return;
    end
    if (!tick) return;
    if (m_flashing) begin
      if (night_mode) m_fl = !m_fl;
      else begin
        m_flashing = 0; m_phase = 0; m_rem = ALL_RED_TIME; m_fl = 0;
      end
      return;
    end
    if (m_rem > 1) begin
      m_rem--;
      return;
    end
    if (m_phase == 0 || m_phase == 3) begin
      m_ped = 0;
      if (night_mode) begin
        m_flashing = 1; m_fl = 0;
        return;
      end
    end
    m_phase = (m_phase + 1) % 6;
    m_rem   = dur[m_phase];
  endtask

  function automatic logic [2:0] exp_lamp(bit is_row);
    if (m_flashing) begin
      if (!m_fl) return 3'b000;
      return is_row ? 3'b010 : 3'b100;
    end
    return is_row ? row_lamp_of[m_phase] : col_lamp_of[m_phase];
  endfunction

  // Ticks until this direction's own green begins (or current phase end if lit).
  function automatic int exp_value(bit is_row);
    int green_phase, sum, p;
    logic [2:0] lamp;
    green_phase = is_row ? 1 : 4;
    lamp = is_row ? row_lamp_of[m_phase] : col_lamp_of[m_phase];
    sum = m_rem;
    if (lamp != 3'b100) return sum;
    p = (m_phase + 1) % 6;
    while (p != green_phase) begin
      sum += dur[p];
      p = (p + 1) % 6;
    end
    return sum;
  endfunction

  function automatic logic [DW-1:0] encode(int value, bit blank);
    logic [DW-1:0] r;
    int v, lim;
    r = '0;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim *= 10;
    lim -= 1;
    v = (value > lim) ? lim : value;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = blank ? 7'b0 : seg_tab[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string name);
    check({name, "_row_lamp"}, 32'(row_traffic_lights), 32'(exp_lamp(1)));
    check({name, "_col_lamp"}, 32'(column_traffic_lights), 32'(exp_lamp(0)));
    check({name, "_row_disp"}, 32'(row_display), 32'(encode(exp_value(1), m_flashing)));
    check({name, "_col_disp"}, 32'(column_display), 32'(encode(exp_value(0), m_flashing)));
  endtask

  task automatic check_const(string name, logic [2:0] rl, logic [2:0] cl, int rv, int cv, bit blank);
    check({name, "_row_lamp"}, 32'(row_traffic_lights), 32'(rl));
    check({name, "_col_lamp"}, 32'(column_traffic_lights), 32'(cl));
    check({name, "_row_disp"}, 32'(row_display), 32'(encode(rv, blank)));
    check({name, "_col_disp"}, 32'(column_display), 32'(encode(cv, blank)));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic run(int n, string name);
    for (int i = 0; i < n; i++) begin
      cycle();
      check_model(name);
    end
  endtask

  typedef struct {
    bit         rst_n;
    bit         tk;
    bit         nt;
    logic [2:0] row_l;
    logic [2:0] col_l;
    int         row_v;
    int         col_v;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n_cg, n_rg, n_ry, n_cy, n_ar, k;
    bit found;

    tbl[0] = '{0, 1, 0, 3'b100, 3'b100, 2, 34};
    tbl[1] = '{0, 1, 0, 3'b100, 3'b100, 2, 34};
    tbl[2] = '{1, 1, 0, 3'b100, 3'b100, 1, 33};
    tbl[3] = '{1, 1, 0, 3'b001, 3'b100, 25, 32};
    tbl[4] = '{1, 0, 0, 3'b001, 3'b100, 25, 32};
    tbl[5] = '{1, 1, 0, 3'b001, 3'b100, 24, 31};
    tbl[6] = '{1, 0, 1, 3'b001, 3'b100, 24, 31};
    tbl[7] = '{0, 0, 0, 3'b100, 3'b100, 2, 34};

    model_reset();
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst_n; tick = tbl[i].tk; night_mode = tbl[i].nt;
      cycle();
      check_const($sformatf("tbl%0d", i), tbl[i].row_l, tbl[i].col_l, tbl[i].row_v, tbl[i].col_v, 1'b0);
    end

    // One full cycle of 64 ticks returns to the reset picture.
    reset = 1; tick = 1; night_mode = 0;
    n_cg = 0; n_rg = 0; n_ry = 0; n_cy = 0; n_ar = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      check_model("cycle");
      if (column_traffic_lights == 3'b001) n_cg++;
      if (row_traffic_lights == 3'b001) n_rg++;
      if (row_traffic_lights == 3'b010) n_ry++;
      if (column_traffic_lights == 3'b010) n_cy++;
      if (row_traffic_lights == 3'b100 && column_traffic_lights == 3'b100) n_ar++;
    end
    check("cycle_col_green_ticks", 32'(n_cg), 32'd25);
    check("cycle_row_green_ticks", 32'(n_rg), 32'd25);
    check("cycle_row_yellow_ticks", 32'(n_ry), 32'd5);
    check("cycle_col_yellow_ticks", 32'(n_cy), 32'd5);
    check("cycle_all_red_ticks", 32'(n_ar), 32'd4);
    check_const("cycle_end", 3'b100, 3'b100, 2, 34, 1'b0);

    // Freeze mid row green with tick held low.
    run(7, "to_green");
    check_const("pre_freeze", 3'b001, 3'b100, 20, 27, 1'b0);
    tick = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_const("freeze", 3'b001, 3'b100, 20, 27, 1'b0);
    end
    tick = 1;
    cycle();
    check_const("resume", 3'b001, 3'b100, 19, 26, 1'b0);

    // Night request during green waits for the RED_B boundary.
    night_mode = 1;
    run(25, "night_wait");
    check_const("night_redb", 3'b100, 3'b100, 33, 1, 1'b0);
    cycle();
    check_const("flash0", 3'b000, 3'b000, 0, 0, 1'b1);
    cycle();
    check_const("flash1", 3'b010, 3'b100, 0, 0, 1'b1);
    cycle();
    check_const("flash2", 3'b000, 3'b000, 0, 0, 1'b1);
    night_mode = 0;
    cycle();
    check_const("night_exit", 3'b100, 3'b100, 2, 34, 1'b0);

    // Reset mid COL_YELLOW and mid FLASH.
    run(60, "to_col_yellow");
    check_const("mid_col_yellow", 3'b100, 3'b010, 6, 4, 1'b0);
    reset = 0;
    cycle();
    check_const("rst_col_yellow", 3'b100, 3'b100, 2, 34, 1'b0);
    reset = 1; night_mode = 1;
    run(3, "to_flash");
    check_const("mid_flash", 3'b010, 3'b100, 0, 0, 1'b1);
    reset = 0;
    cycle();
    check_const("rst_flash", 3'b100, 3'b100, 2, 34, 1'b0);
    reset = 1; night_mode = 0;

    if (PED_EN) begin
      run(7, "ped_to_green");
      check_const("ped_at20", 3'b001, 3'b100, 20, 27, 1'b0);
      ped_request = 1;
      cycle();
      ped_request = 0;
      check_const("ped_short", 3'b001, 3'b100, 5, 12, 1'b0);
      k = 0;
      found = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
        cycle();
        check_model("ped_run");
        if (row_traffic_lights == 3'b010) begin
          found = 1; k = i;
        end
      end
      check("ped_yellow_after", 32'(k), 32'd5);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        cycle();
        check_model("ped_seek3");
        if (row_traffic_lights == 3'b001 && row_display == encode(3, 1'b0)) found = 1;
      end
      check("ped_found_row3", 32'(found), 32'd1);
      ped_request = 1;
      cycle();
      ped_request = 0;
      check_const("ped_no_short", 3'b001, 3'b100, 2, 9, 1'b0);
    end

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) != 0);
      tick        = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) night_mode = ~night_mode;
      ped_request = ($urandom_range(0, 29) == 0);
      cycle();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
